// File: rtl/wall_pkg.sv
// wall_pkg: shared types and default constants for the obstacle-wall datapath.
//   coord_t  - 8-bit screen coordinate
//   state_t  - wall controller states
//   *_DEFAULT constants - default screen geometry used as parameter defaults
//   gap_bottom_sat() - bottom of the gap window, clipped to the last screen row
package wall_pkg;

    typedef logic [7:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SCROLL,
        ST_HALT
    } state_t;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;
    localparam int GAP_DEFAULT      = 40;
    localparam int BIRD_X_DEFAULT   = 40;

    // The sum is formed in 9 bits so a tall height plus the gap cannot wrap
    // before the comparison against the bottom row.
    function automatic coord_t gap_bottom_sat(input coord_t height, input int gap,
                                              input int screen_h);
        logic [8:0] sum;
        coord_t     result;
        sum = {1'b0, height} + 9'(gap);
        if (sum > 9'(screen_h - 1)) begin
            result = coord_t'(screen_h - 1);
        end else begin
            result = sum[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/wall_scroll_controller_step_prescaler.sv
// step_prescaler: divides accepted frame ticks down to scroll-step strobes.
//   clk, reset  - clock and synchronous active-high reset
//   clear       - zero the tick counter (new wall being latched)
//   enable      - ticks are counted only while enabled (scrolling, no crash)
//   frame_tick  - one-cycle pulse per frame
//   step        - combinational strobe, high in the cycle of every
//                 TICKS_PER_STEP-th accepted tick
module step_prescaler
    import wall_pkg::*;
#(
    parameter int TICKS_PER_STEP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic frame_tick,
    output logic step
);

    localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_STEP - 1);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    // The strobe is combinational so the controller can register the moved
    // wall position in the same cycle the tick arrives.
    always_comb begin
        count_next = count_reg;
        step       = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (enable && frame_tick) begin
            if (count_reg == LAST_TICK) begin
                count_next = '0;
                step       = 1'b1;
            end else begin
                count_next = count_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/wall_scroll_controller.sv
// wall_scroll_controller: sequences one obstacle wall at a time.
//   Requests a height, latches the gap window, scrolls the wall left on frame
//   ticks, pulses score when the wall passes the bird column, and freezes on
//   crash until the next start.
//   clk, reset  - clock and synchronous active-high reset
//   start       - begin/restart play (honoured in IDLE and HALT only)
//   crash       - game-over level (honoured in FETCH, LATCH, SCROLL)
//   frame_tick  - one-cycle pulse per frame
//   height_in   - generator height, valid the cycle after height_req
//   height_req  - one-cycle advance strobe to the generator
//   wall_x, gap_top, gap_bottom, wall_valid - wall geometry for render/collide
//   score_pulse - one-cycle pulse as the wall crosses BIRD_X
// All outputs come straight from registers.
module wall_scroll_controller
    import wall_pkg::*;
#(
    parameter int SCREEN_W       = SCREEN_W_DEFAULT,
    parameter int SCREEN_H       = SCREEN_H_DEFAULT,
    parameter int GAP            = GAP_DEFAULT,
    parameter int STEP           = 1,
    parameter int BIRD_X         = BIRD_X_DEFAULT,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       crash,
    input  logic       frame_tick,
    input  logic [7:0] height_in,
    output logic       height_req,
    output logic [7:0] wall_x,
    output logic [7:0] gap_top,
    output logic [7:0] gap_bottom,
    output logic       wall_valid,
    output logic       score_pulse
);

    localparam coord_t SPAWN_X  = coord_t'(SCREEN_W - 1);
    localparam coord_t STEP_PX  = coord_t'(STEP);
    localparam coord_t BIRD_COL = coord_t'(BIRD_X);

    state_t state_reg, state_next;
    coord_t wall_x_reg, wall_x_next;
    coord_t gap_top_reg, gap_top_next;
    coord_t gap_bottom_reg, gap_bottom_next;
    logic   wall_valid_reg, wall_valid_next;
    logic   height_req_reg, height_req_next;
    logic   score_reg, score_next;

    logic   step;
    logic   prescale_clear;
    logic   prescale_enable;
    coord_t moved_x;

    // A coincident crash must not count the tick, so it gates the enable.
    assign prescale_clear  = (state_reg == ST_LATCH);
    assign prescale_enable = (state_reg == ST_SCROLL) && !crash;

    step_prescaler #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_step_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (prescale_clear),
        .enable    (prescale_enable),
        .frame_tick(frame_tick),
        .step      (step)
    );

    assign moved_x = wall_x_reg - STEP_PX;

    always_comb begin
        state_next      = state_reg;
        wall_x_next     = wall_x_reg;
        gap_top_next    = gap_top_reg;
        gap_bottom_next = gap_bottom_reg;
        wall_valid_next = wall_valid_reg;
        score_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wall_valid_next = 1'b0;
                state_next      = crash ? ST_HALT : ST_LATCH;
            end
            ST_LATCH: begin
                // On crash the fetched height is simply never captured.
                if (crash) begin
                    state_next = ST_HALT;
                end else begin
                    gap_top_next    = height_in;
                    gap_bottom_next = gap_bottom_sat(height_in, GAP, SCREEN_H);
                    wall_x_next     = SPAWN_X;
                    wall_valid_next = 1'b1;
                    state_next      = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (crash) begin
                    state_next = ST_HALT;
                end else if (step) begin
                    if (wall_x_reg < STEP_PX) begin
                        // Wall would leave the screen: retire it in place.
                        wall_valid_next = 1'b0;
                        state_next      = ST_FETCH;
                    end else begin
                        wall_x_next = moved_x;
                        // Position only decreases, so this fires once per wall.
                        score_next  = (wall_x_reg >= BIRD_COL) && (moved_x < BIRD_COL);
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    wall_valid_next = 1'b0;
                    state_next      = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // FETCH always lasts exactly one cycle, so the request can never be
        // high in two consecutive cycles.
        height_req_next = (state_next == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            wall_x_reg     <= SPAWN_X;
            gap_top_reg    <= '0;
            gap_bottom_reg <= '0;
            wall_valid_reg <= 1'b0;
            height_req_reg <= 1'b0;
            score_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wall_x_reg     <= wall_x_next;
            gap_top_reg    <= gap_top_next;
            gap_bottom_reg <= gap_bottom_next;
            wall_valid_reg <= wall_valid_next;
            height_req_reg <= height_req_next;
            score_reg      <= score_next;
        end
    end

    assign height_req  = height_req_reg;
    assign wall_x      = wall_x_reg;
    assign gap_top     = gap_top_reg;
    assign gap_bottom  = gap_bottom_reg;
    assign wall_valid  = wall_valid_reg;
    assign score_pulse = score_reg;

endmodule
